lbp_host_ctrl: RTL and testbench

- Host-side responder facing the LBP engine: serves `gray_req` reads from an external gray-image SRAM and sinks `lbp_valid` writes into an external result SRAM.
- Sequences the run: `gray_ready` assertion, `finish` detection, write accounting, protocol-error flags and a watchdog.
- It is the synthesizable replacement for the bench-side image/result memories in the LBP subsystem.

---
 rtl/lbp_pkg.sv | 23 ++
 rtl/lbp_host_wdog.sv | 41 ++++
 rtl/lbp_host_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lbp_host_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP host-side controller.
//   ADDR_W / DATA_W / N_PIX : default image geometry (128x128, 8-bit pixels)
//   lbp_state_e             : run sequencer states
//   ERR_*                   : bit positions inside err_flags
package lbp_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int N_PIX  = 16384;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } lbp_state_e;

  localparam int ERR_REQ_NOT_READY  = 0;
  localparam int ERR_WR_OUTSIDE_RUN = 1;
  localparam int ERR_TIMEOUT        = 2;

endpackage

// File: rtl/lbp_host_wdog.sv
// Run watchdog: counts enabled cycles and flags the cycle on which the count
// reaches LIMIT-1.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart count from zero (wins over en_i)
//   en_i          : count this cycle
//   expire_o      : en_i and count == LIMIT-1 (combinational)
module lbp_host_wdog #(
  parameter int LIMIT = 100000000,
  parameter int CNT_W = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/lbp_host_ctrl.sv
// Host-side responder for the LBP engine: serves engine pixel reads from an
// external image SRAM, forwards engine results into an external result SRAM,
// and sequences a run (ready, finish, drain, done, watchdog, error flags).
//   clk, reset           : clock, asynchronous active-low reset
//   start                : one-cycle pulse, begins a run from IDLE/DONE/TIMEOUT
//   gray_ready/req/addr  : engine read handshake, gray_data returned 1 cycle later
//   lbp_valid/addr/data  : engine result writes, accepted only while running
//   finish               : engine completion level
//   img_rd_*             : image SRAM port (1-cycle synchronous read)
//   res_wr_*             : result SRAM port (writes delayed 1 cycle)
//   done, wr_count       : run complete level, accepted write count (saturating)
//   err_flags            : sticky {timeout, write_outside_run, req_while_not_ready}
//   dbg_state            : current sequencer state
//
// Read handshake: a read is taken in every cycle where gray_req and gray_ready
// are both high; there is no back-pressure beyond gray_ready, one read may be
// issued per cycle, and its data is on gray_data in the following cycle.
// gray_req while gray_ready is low is dropped and flagged.
module lbp_host_ctrl #(
  parameter int ADDR_W         = lbp_pkg::ADDR_W,
  parameter int DATA_W         = lbp_pkg::DATA_W,
  parameter int N_PIX          = lbp_pkg::N_PIX,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TO_W           = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 gray_ready,
  input  logic                 gray_req,
  input  logic [ADDR_W-1:0]    gray_addr,
  output logic [DATA_W-1:0]    gray_data,
  input  logic                 lbp_valid,
  input  logic [ADDR_W-1:0]    lbp_addr,
  input  logic [DATA_W-1:0]    lbp_data,
  input  logic                 finish,
  output logic                 img_rd_en,
  output logic [ADDR_W-1:0]    img_rd_addr,
  input  logic [DATA_W-1:0]    img_rd_data,
  output logic                 res_wr_en,
  output logic [ADDR_W-1:0]    res_wr_addr,
  output logic [DATA_W-1:0]    res_wr_data,
  output logic                 done,
  output logic [ADDR_W:0]      wr_count,
  output logic [2:0]           err_flags,
  output lbp_pkg::lbp_state_e  dbg_state
);

  import lbp_pkg::*;

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(N_PIX);

  lbp_state_e state_q, state_d;
  logic       in_run;
  logic       run_start;
  logic       wdog_expire;

  // ---------------------------------------------------------------- FSM
  assign in_run = (state_q == ST_RUN);

  // start only takes effect from the resting states; it is ignored mid-run.
  assign run_start = start &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                      (state_q == ST_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    gray_ready = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        done = (state_q == ST_DONE);
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        gray_ready = 1'b1;
        // finish has priority over a watchdog expiry in the same cycle
        if (finish)           state_d = ST_DRAIN;
        else if (wdog_expire) state_d = ST_TIMEOUT;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = state_q;

  // ----------------------------------------------------------- watchdog
  lbp_host_wdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (TO_W)
  ) u_wdog (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (run_start),
    .en_i     (in_run),
    .expire_o (wdog_expire)
  );

  // ---------------------------------------------------------- read path
  logic              rd_pend_q;
  logic [DATA_W-1:0] gray_data_q;

  assign img_rd_en   = gray_req & gray_ready;
  assign img_rd_addr = gray_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q   <= 1'b0;
      gray_data_q <= '0;
    end else begin
      rd_pend_q <= img_rd_en;
      if (rd_pend_q) gray_data_q <= img_rd_data;
    end
  end

  // SRAM data passes straight through in the cycle it arrives so the engine
  // sees it one cycle after its request; the register holds it afterwards.
  assign gray_data = rd_pend_q ? img_rd_data : gray_data_q;

  // --------------------------------------------------------- write path
  logic              wr_accept;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [2:0]        err_q, err_d;

  // Writes are taken in every RUN cycle, including the one where finish is
  // sampled; the DRAIN cycle then pushes that last write out to the SRAM.
  assign wr_accept = lbp_valid & in_run;

  always_comb begin
    wr_count_d = wr_count_q;
    if (run_start) begin
      wr_count_d = '0;
    end else if (wr_accept && (wr_count_q != CNT_MAX)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (run_start) begin
      err_d = '0;
    end else begin
      if (gray_req && !gray_ready)              err_d[ERR_REQ_NOT_READY]  = 1'b1;
      if (lbp_valid && !in_run)                 err_d[ERR_WR_OUTSIDE_RUN] = 1'b1;
      if (in_run && !finish && wdog_expire)     err_d[ERR_TIMEOUT]        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      err_q      <= '0;
    end else begin
      wr_en_q    <= wr_accept;
      if (wr_accept) begin
        wr_addr_q <= lbp_addr;
        wr_data_q <= lbp_data;
      end
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  assign res_wr_en   = wr_en_q;
  assign res_wr_addr = wr_addr_q;
  assign res_wr_data = wr_data_q;
  assign wr_count    = wr_count_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_lbp_host_ctrl.sv
module tb_lbp_host_ctrl;
  import lbp_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int NP  = 16384;
  localparam int TO  = 17000;
  localparam int TOW = 15;

  // ------------------------------------------------ clock / reset block
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, gray_req = 1'b0, lbp_valid = 1'b0, finish = 1'b0;
  logic [AW-1:0] gray_addr = '0, lbp_addr = '0;
  logic [DW-1:0] lbp_data = '0;
  logic [DW-1:0] img_rd_data = '0;
  logic          gray_ready, img_rd_en, res_wr_en, done;
  logic [DW-1:0] gray_data, res_wr_data;
  logic [AW-1:0] img_rd_addr, res_wr_addr;
  logic [AW:0]   wr_count;
  logic [2:0]    err_flags;
  lbp_state_e    dbg_state;

  lbp_host_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .N_PIX(NP), .TIMEOUT_CYCLES(TO), .TO_W(TOW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .gray_ready(gray_ready),
    .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .img_rd_en(img_rd_en), .img_rd_addr(img_rd_addr),
    .img_rd_data(img_rd_data), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_wr_data(res_wr_data), .done(done), .wr_count(wr_count),
    .err_flags(err_flags), .dbg_state(dbg_state)
  );

  // -------------------------------------------------- external memories
  logic [DW-1:0] img_mem [NP];
  logic [DW-1:0] res_mem [NP];

  always @(posedge clk) if (img_rd_en) img_rd_data <= img_mem[img_rd_addr];
  always @(posedge clk) if (res_wr_en) res_mem[res_wr_addr] <= res_wr_data;

  // ------------------------------------------------------ check helper
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------- reference model
  // Run-level view: running / draining / done flags, cycles spent running,
  // accepted write count and sticky errors, plus the queue of writes that
  // must appear on the result SRAM port.
  bit            m_run = 0, m_drain = 0, m_done = 0, was_drain = 0;
  logic [2:0]    m_err = '0;
  int            m_cnt = 0, m_run_len = 0;
  logic [AW+DW-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_drain = 0; m_done = 0; m_err = '0; m_cnt = 0; m_run_len = 0;
      exp_q.delete();
    end else if (m_run) begin
      if (lbp_valid) begin
        exp_q.push_back({lbp_addr, lbp_data});
        if (m_cnt < NP) m_cnt++;
      end
      if (finish) begin
        m_run = 0; m_drain = 1;
      end else if (m_run_len == TO - 1) begin
        m_run = 0; m_err[2] = 1'b1;
      end else begin
        m_run_len++;
      end
    end else begin
      was_drain = m_drain;
      if (m_drain) begin m_drain = 0; m_done = 1; end
      if (gray_req)  m_err[0] = 1'b1;
      if (lbp_valid) m_err[1] = 1'b1;
      if (start && !was_drain) begin
        m_err = '0; m_cnt = 0; m_run_len = 0; m_run = 1; m_done = 0;
      end
    end
  end

  // ---------------------------------------------- scoreboard / monitor
  bit               rd_pend = 0;
  logic [DW-1:0]    rd_val = '0, last_gd = '0;
  logic [AW+DW-1:0] w;

  always @(negedge clk) begin
    if (!reset) begin
      rd_pend = 0; last_gd = '0;
    end else begin
      chk("gray_ready", gray_ready, m_run);
      chk("done", done, m_done);
      chk("err_flags", err_flags, m_err);
      chk("wr_count", wr_count, m_cnt);
      chk("img_rd_en", img_rd_en, gray_req & m_run);
      if (gray_req & m_run) chk("img_rd_addr", img_rd_addr, gray_addr);
      if (rd_pend) last_gd = rd_val;
      chk("gray_data", gray_data, last_gd);
      rd_pend = gray_req & m_run;
      rd_val  = img_mem[gray_addr];
      if (res_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("res_wr_unexpected", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          chk("res_wr_addr", res_wr_addr, w[AW+DW-1:DW]);
          chk("res_wr_data", res_wr_data, w[DW-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------- driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------- stimulus
  int rd_cnt;

  initial begin
    for (int i = 0; i < NP; i++) begin
      img_mem[i] = DW'($urandom_range(0, 255));
      res_mem[i] = '0;
    end
    img_mem[0]   = 8'h10;
    img_mem[1]   = 8'h20;
    img_mem[129] = 8'h30;

    // reset
    #2 reset = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_res_wr_en", res_wr_en, 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cyc(); reset = 1'b1;

    // read request while idle
    cyc(); gray_req = 1'b1; gray_addr = 14'd5;
    @(negedge clk);
    chk("idle_rd_en", img_rd_en, 0);
    cyc(); gray_req = 1'b0;
    @(negedge clk);
    chk("idle_req_err", err_flags, 3'b001);
    chk("idle_gray_data", gray_data, 0);

    // start clears the flag, ready the next cycle
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("start_err_clr", err_flags, 0);
    chk("start_ready", gray_ready, 1);
    chk("start_state", 32'(dbg_state), 32'(ST_RUN));

    // three back-to-back reads
    rd_cnt = 0;
    cyc(); gray_req = 1'b1; gray_addr = 14'd0;
    @(negedge clk); rd_cnt += int'(img_rd_en);
    cyc(); gray_addr = 14'd1;
    @(negedge clk); rd_cnt += int'(img_rd_en); chk("b2b_d0", gray_data, 8'h10);
    cyc(); gray_addr = 14'd129;
    @(negedge clk); rd_cnt += int'(img_rd_en); chk("b2b_d1", gray_data, 8'h20);
    cyc(); gray_req = 1'b0;
    @(negedge clk); rd_cnt += int'(img_rd_en); chk("b2b_d2", gray_data, 8'h30);
    cyc();
    @(negedge clk); rd_cnt += int'(img_rd_en);
    chk("b2b_hold", gray_data, 8'h30);
    chk("b2b_rd_cycles", rd_cnt, 3);

    // random reads
    repeat (40) begin
      cyc();
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = AW'($urandom_range(0, NP - 1));
    end

    // full image of writes with random reads interleaved
    for (int i = 0; i < NP; i++) begin
      cyc();
      lbp_valid = 1'b1;
      lbp_addr  = i[AW-1:0];
      lbp_data  = i[DW-1:0];
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = AW'($urandom_range(0, NP - 1));
    end
    // one more write in the finish cycle: accepted, count saturates
    cyc(); lbp_valid = 1'b1; lbp_addr = '0; lbp_data = 8'hAA; finish = 1'b1; gray_req = 1'b0;
    cyc(); lbp_valid = 1'b0; finish = 1'b0; start = 1'b1;   // start ignored in DRAIN
    @(negedge clk);
    chk("drain_ready", gray_ready, 0);
    chk("drain_done", done, 0);
    chk("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("drain_last_wr", res_wr_en, 1);
    chk("sat_wr_count", wr_count, NP);
    cyc(); start = 1'b0;
    @(negedge clk);
    chk("done_level", done, 1);
    chk("done_state", 32'(dbg_state), 32'(ST_DONE));
    chk("res_mem_0", res_mem[0], 8'hAA);
    chk("res_mem_1", res_mem[1], 8'h01);
    chk("res_mem_300", res_mem[300], 8'h2C);
    chk("res_mem_last", res_mem[NP-1], 8'hFF);

    // write after done is dropped and flagged
    cyc(); lbp_valid = 1'b1; lbp_addr = 14'd7; lbp_data = 8'h55;
    cyc(); lbp_valid = 1'b0;
    @(negedge clk);
    chk("late_wr_en", res_wr_en, 0);
    chk("late_wr_err", err_flags, 3'b010);
    chk("late_wr_count", wr_count, NP);
    cyc();
    chk("late_res_mem_7", res_mem[7], 8'h07);

    // start together with a write in DONE: flag cleared, write dropped
    cyc(); start = 1'b1; lbp_valid = 1'b1; lbp_addr = 14'd9; lbp_data = 8'h99;
    cyc(); start = 1'b0; lbp_valid = 1'b0;
    @(negedge clk);
    chk("restart_err", err_flags, 0);
    chk("restart_wr_en", res_wr_en, 0);
    chk("restart_count", wr_count, 0);

    // timeout run (a mid-run start pulse must not restart the watchdog)
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (TO - 3) cyc();
    @(negedge clk);
    chk("to_last_run_ready", gray_ready, 1);
    cyc();
    @(negedge clk);
    chk("to_state", 32'(dbg_state), 32'(ST_TIMEOUT));
    chk("to_err", err_flags, 3'b100);
    chk("to_ready", gray_ready, 0);
    chk("to_done", done, 0);

    // restart from TIMEOUT, finish on the expiry cycle
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (TO - 2) cyc();
    cyc(); finish = 1'b1;
    cyc(); finish = 1'b0;
    @(negedge clk);
    chk("fin_vs_to_state", 32'(dbg_state), 32'(ST_DRAIN));
    chk("fin_vs_to_err", err_flags, 0);
    cyc();
    @(negedge clk);
    chk("fin_vs_to_done", done, 1);

    // reset in the middle of a run with a write in flight
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (5) begin
      cyc(); lbp_valid = 1'b1;
      lbp_addr = AW'($urandom_range(0, NP - 1));
      lbp_data = DW'($urandom_range(0, 255));
    end
    cyc();
    chk("pre_reset_wr_en", res_wr_en, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", res_wr_en, 0);
    chk("mid_rst_ready", gray_ready, 0);
    chk("mid_rst_count", wr_count, 0);
    chk("mid_rst_err", err_flags, 0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    lbp_valid = 1'b0;
    cyc(); cyc(); reset = 1'b1;

    // clean run after reset
    cyc(); start = 1'b1;
    cyc(); start = 1'b0;
    repeat (10) begin
      cyc(); lbp_valid = 1'b1;
      lbp_addr = AW'($urandom_range(0, NP - 1));
      lbp_data = DW'($urandom_range(0, 255));
      gray_req  = 1'($urandom_range(0, 1));
      gray_addr = AW'($urandom_range(0, NP - 1));
    end
    cyc(); lbp_valid = 1'b0; gray_req = 1'b0; finish = 1'b1;
    cyc(); finish = 1'b0;
    cyc();
    @(negedge clk);
    chk("post_rst_done", done, 1);
    chk("post_rst_count", wr_count, 10);
    chk("post_rst_err", err_flags, 0);

    repeat (3) cyc();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
